// File: rtl/apb_sram_arbiter_if.sv
// Requester command/response channels, APB master bus and the watchdog pulse.
// The master modport is the arbiter's view; slave is the environment (requesters + APB slave).
interface apb_sram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req0_valid;
  logic                  req0_write;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  req0_ready;
  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_rdata;
  logic                  rsp0_err;

  logic                  req1_valid;
  logic                  req1_write;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  req1_ready;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_rdata;
  logic                  rsp1_err;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;
  logic                  timeout_evt;

  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr,
    output timeout_evt
  );

  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr,
    input  timeout_evt
  );
endinterface

// File: rtl/apb_sram_arbiter.sv
// Two-port round-robin arbiter feeding a single-outstanding APB master sequencer,
// with a watchdog that aborts ACCESS phases whose pready never arrives.
module apb_sram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input logic                clk,
  input logic                rst,
  apb_sram_arbiter_if.master bus
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state_q, state_d;
  logic                  pref_q, pref_d;
  logic                  owner_q, owner_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rsp0_q, rsp0_d;
  logic                  rsp1_q, rsp1_d;
  logic                  err_q, err_d;
  logic                  tevt_q, tevt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic grant_vld;
  logic grant_port;
  logic ready0;
  logic ready1;
  logic sel;

  // pref_q names the port that wins a tie; it flips to the loser on every grant
  always_comb begin
    grant_vld = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_port = pref_q;
    end else begin
      grant_port = bus.req1_valid;
    end
  end

  always_comb begin
    state_d = state_q;
    pref_d  = pref_q;
    owner_d = owner_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rsp0_d  = 1'b0;
    rsp1_d  = 1'b0;
    err_d   = 1'b0;
    tevt_d  = 1'b0;
    rdata_d = '0;
    ready0  = 1'b0;
    ready1  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          ready0  = ~grant_port;
          ready1  = grant_port;
          owner_d = grant_port;
          pref_d  = ~grant_port;
          write_d = grant_port ? bus.req1_write : bus.req0_write;
          addr_d  = grant_port ? bus.req1_addr : bus.req0_addr;
          wdata_d = '0;
          if (write_d) begin
            wdata_d = grant_port ? bus.req1_wdata : bus.req0_wdata;
          end
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CW'(1);
        state_d = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          state_d = IDLE;
          rsp0_d  = ~owner_q;
          rsp1_d  = owner_q;
          err_d   = bus.pslverr;
          if (!write_q && !bus.pslverr) begin
            rdata_d = bus.prdata;
          end
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d = IDLE;
          rsp0_d  = ~owner_q;
          rsp1_d  = owner_q;
          err_d   = 1'b1;
          tevt_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // reset wins over the combinational accept so no command is consumed while held
    if (rst) begin
      ready0 = 1'b0;
      ready1 = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pref_q  <= 1'b0;
      owner_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
      err_q   <= 1'b0;
      tevt_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      pref_q  <= pref_d;
      owner_q <= owner_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rsp0_q  <= rsp0_d;
      rsp1_q  <= rsp1_d;
      err_q   <= err_d;
      tevt_q  <= tevt_d;
      rdata_q <= rdata_d;
    end
  end

  assign sel             = (state_q != IDLE);
  assign bus.psel        = sel;
  assign bus.penable     = (state_q == ACCESS);
  assign bus.pwrite      = sel & write_q;
  assign bus.paddr       = sel ? addr_q : '0;
  assign bus.pwdata      = sel ? wdata_q : '0;
  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.rsp0_valid  = rsp0_q;
  assign bus.rsp1_valid  = rsp1_q;
  assign bus.rsp0_err    = rsp0_q & err_q;
  assign bus.rsp1_err    = rsp1_q & err_q;
  assign bus.rsp0_rdata  = rsp0_q ? rdata_q : '0;
  assign bus.rsp1_rdata  = rsp1_q ? rdata_q : '0;
  assign bus.timeout_evt = tevt_q;
endmodule

// File: tb/tb_apb_sram_arbiter.sv
// Bench for apb_sram_arbiter: transaction-level model + behavioural APB SRAM slave,
// directed scenarios with literal latencies, then a randomized soak.
module tb_apb_sram_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;
  localparam int unsigned SRAM_BYTES = 32'h400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_sram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  apb_sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_err = 0;
  int n_checks = 0;
  int cyc = 0;
  bit chk_en = 0;

  // requester side
  bit            p_valid [2];
  bit            p_write [2];
  logic [AW-1:0] p_addr  [2];
  logic [DW-1:0] p_wdata [2];
  bit rand_mode = 0;
  int force_k = -1;
  bit rst_drv = 1;

  // transaction model
  bit            m_busy = 0;
  int            m_t0 = 0;
  int            m_k = 0;
  int            m_port = 0;
  bit            m_write = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  bit            m_pref = 0;
  int            rsp_due = -1;
  int            rsp_port = 0;
  logic [DW-1:0] rsp_rdata = '0;
  bit            rsp_err = 0;
  bit            rsp_tevt = 0;
  logic [DW-1:0] ref_mem [int unsigned];
  logic [DW-1:0] slv_mem [int unsigned];

  // observations of the DUT used by the literal checks
  int obs_acc = 0, obs_psel_rise = 0, obs_pen_rise = 0, obs_rsp_cyc = 0, obs_rsp_cnt = 0;
  int obs_tevt_cyc = 0, obs_pen_run = 0, obs_psel_run = 0, obs_psel_run_max = 0;
  int grant_log [$];
  logic [DW-1:0] obs_rdata = '0;
  bit obs_err = 0;
  bit prev_psel = 0, prev_pen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(a >> 2)) return ref_mem[a >> 2];
    return '0;
  endfunction

  function automatic logic [DW-1:0] slv_rd(input logic [AW-1:0] a);
    if (slv_mem.exists(a >> 2)) return slv_mem[a >> 2];
    return '0;
  endfunction

  function automatic int winner();
    if (m_busy || rst_drv) return -1;
    if (p_valid[0] && p_valid[1]) return int'(m_pref);
    if (p_valid[0]) return 0;
    if (p_valid[1]) return 1;
    return -1;
  endfunction

  function automatic int pick_k();
    int r;
    if (force_k >= 0) return force_k;
    r = int'($urandom_range(0, 11));
    if (r == 11) return 99;
    if (r == 10) return int'(TO) - 1;
    return r % 4;
  endfunction

  task automatic new_cmd(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_valid[p] = 1;
    p_write[p] = w;
    p_addr[p]  = a;
    p_wdata[p] = d;
  endtask

  task automatic gen();
    for (int i = 0; i < 2; i++) begin
      if (!p_valid[i] && $urandom_range(0, 2) == 0)
        new_cmd(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 32'h11F)) << 2, $urandom);
    end
    rst_drv = ($urandom_range(0, 399) == 0);
  endtask

  // requesters and a slave with a word-addressed SRAM; pready/pslverr are noise outside the wait point
  task automatic drive();
    int t;
    bit hit;
    rst = rst_drv;
    bus.req0_valid = p_valid[0];
    bus.req0_write = p_write[0];
    bus.req0_addr  = p_addr[0];
    bus.req0_wdata = p_wdata[0];
    bus.req1_valid = p_valid[1];
    bus.req1_write = p_write[1];
    bus.req1_addr  = p_addr[1];
    bus.req1_wdata = p_wdata[1];
    t = cyc - m_t0;
    hit = m_busy && t >= 2 && (t - 2) == m_k;
    bus.prdata  = $urandom;
    bus.pslverr = 1'($urandom_range(0, 1));
    bus.pready  = (m_busy && t >= 2) ? 1'b0 : 1'($urandom_range(0, 1));
    if (hit) begin
      bus.pready  = 1'b1;
      bus.pslverr = (bus.paddr >= SRAM_BYTES);
      if (!bus.pwrite && !bus.pslverr) bus.prdata = slv_rd(bus.paddr);
      else if (bus.pwrite && !bus.pslverr && !rst_drv) slv_mem[bus.paddr >> 2] = bus.pwdata;
    end
  endtask

  task automatic compare();
    int t, w;
    bit e_psel, e_pen, rv0, rv1;
    t = cyc - m_t0;
    e_psel = m_busy && t >= 1;
    e_pen  = m_busy && t >= 2;
    w = winner();
    rv0 = (rsp_due == cyc) && (rsp_port == 0);
    rv1 = (rsp_due == cyc) && (rsp_port == 1);
    chk("req0_ready", bus.req0_ready, w == 0);
    chk("req1_ready", bus.req1_ready, w == 1);
    chk("psel", bus.psel, e_psel);
    chk("penable", bus.penable, e_pen);
    chk("pwrite", bus.pwrite, e_psel && m_write);
    chk("paddr", bus.paddr, e_psel ? m_addr : '0);
    chk("pwdata", bus.pwdata, (e_psel && m_write) ? m_wdata : '0);
    chk("rsp0_valid", bus.rsp0_valid, rv0);
    chk("rsp0_err", bus.rsp0_err, rv0 && rsp_err);
    chk("rsp0_rdata", bus.rsp0_rdata, rv0 ? rsp_rdata : '0);
    chk("rsp1_valid", bus.rsp1_valid, rv1);
    chk("rsp1_err", bus.rsp1_err, rv1 && rsp_err);
    chk("rsp1_rdata", bus.rsp1_rdata, rv1 ? rsp_rdata : '0);
    chk("timeout_evt", bus.timeout_evt, (rsp_due == cyc) && rsp_tevt);
  endtask

  task automatic record();
    if (bus.req0_ready) begin grant_log.push_back(0); obs_acc = cyc; end
    if (bus.req1_ready) begin grant_log.push_back(1); obs_acc = cyc; end
    if (bus.psel && !prev_psel) begin
      obs_psel_rise = cyc;
      obs_pen_run = 0;
      obs_psel_run = 0;
    end
    if (bus.psel) begin
      obs_psel_run++;
      if (obs_psel_run > obs_psel_run_max) obs_psel_run_max = obs_psel_run;
    end
    if (bus.penable && !prev_pen) obs_pen_rise = cyc;
    if (bus.penable) obs_pen_run++;
    if (bus.rsp0_valid || bus.rsp1_valid) begin
      obs_rsp_cnt++;
      obs_rsp_cyc = cyc;
      obs_rdata = bus.rsp0_valid ? bus.rsp0_rdata : bus.rsp1_rdata;
      obs_err = bus.rsp0_valid ? bus.rsp0_err : bus.rsp1_err;
    end
    if (bus.timeout_evt) obs_tevt_cyc = cyc;
    prev_psel = bus.psel;
    prev_pen = bus.penable;
  endtask

  task automatic finish_txn(input bit err, input bit tevt);
    m_busy = 0;
    rsp_due = cyc + 1;
    rsp_port = m_port;
    rsp_err = err;
    rsp_tevt = tevt;
    rsp_rdata = (!m_write && !err) ? ref_rd(m_addr) : '0;
    if (m_write && !err) ref_mem[m_addr >> 2] = m_wdata;
  endtask

  // what the coming clock edge does, at transaction level
  task automatic update();
    int t, w;
    w = winner();
    t = cyc - m_t0;
    if (rst_drv) begin
      m_busy = 0;
      m_pref = 0;
    end else if (!m_busy) begin
      if (w >= 0) begin
        m_busy  = 1;
        m_t0    = cyc;
        m_port  = w;
        m_write = p_write[w];
        m_addr  = p_addr[w];
        m_wdata = p_write[w] ? p_wdata[w] : '0;
        m_k     = pick_k();
        m_pref  = (w == 0);
        p_valid[w] = 0;
      end
    end else if (t >= 2 && (t - 2) == m_k) begin
      finish_txn(m_addr >= SRAM_BYTES, 0);
    end else if (t >= 2 && (t - 1) == int'(TO)) begin
      finish_txn(1, 1);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (rand_mode) gen();
    drive();
    #1;
    if (chk_en) begin
      compare();
      record();
    end
    update();
    @(posedge clk);
    cyc++;
  endtask

  task automatic wait_rsp(input int max, input string nm);
    int c0;
    c0 = obs_rsp_cnt;
    for (int i = 0; i < max && obs_rsp_cnt == c0; i++) step();
    chk({nm, "_rsp_seen"}, obs_rsp_cnt != c0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (m_busy || rsp_due >= cyc); i++) step();
  endtask

  initial begin
    int c0;
    for (int p = 0; p < 2; p++) begin
      p_valid[p] = 0; p_write[p] = 0; p_addr[p] = '0; p_wdata[p] = '0;
    end
    rst_drv = 1;
    step();
    chk_en = 1;
    step();
    step();
    rst_drv = 0;
    step();

    // write then read back through the two ports
    force_k = 0;
    new_cmd(0, 1, 32'h10, 32'hA5A5_0001);
    wait_rsp(20, "t1");
    chk("t1_psel_lat", obs_psel_rise - obs_acc, 1);
    chk("t1_pen_lat", obs_pen_rise - obs_acc, 2);
    chk("t1_rsp_lat", obs_rsp_cyc - obs_acc, 3);
    chk("t1_err", obs_err, 0);

    force_k = 2;
    new_cmd(1, 0, 32'h10, 32'hFFFF_FFFF);
    wait_rsp(20, "t2");
    chk("t2_rsp_lat", obs_rsp_cyc - obs_acc, 5);
    chk("t2_rdata", obs_rdata, 32'hA5A5_0001);
    chk("t2_err", obs_err, 0);

    // continuous contention alternates grants
    force_k = 0;
    grant_log.delete();
    obs_psel_run_max = 0;
    for (int i = 0; i < 200 && grant_log.size() < 6; i++) begin
      for (int p = 0; p < 2; p++)
        if (!p_valid[p]) new_cmd(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)) << 2, $urandom);
      step();
    end
    p_valid[0] = 0;
    p_valid[1] = 0;
    drain();
    chk("t3_grants", grant_log.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < grant_log.size()) chk("t3_grant_order", grant_log[i], i % 2);
    chk("t3_psel_run", obs_psel_run_max, 2);

    // out-of-range read returns slave error
    force_k = 1;
    new_cmd(0, 0, 32'h1000, '0);
    wait_rsp(20, "t4");
    chk("t4_err", obs_err, 1);
    chk("t4_rdata", obs_rdata, 0);

    // watchdog abort
    force_k = 99;
    new_cmd(1, 0, 32'h20, '0);
    wait_rsp(40, "t5");
    chk("t5_rsp_lat", obs_rsp_cyc - obs_acc, 18);
    chk("t5_tevt_lat", obs_tevt_cyc - obs_acc, 18);
    chk("t5_err", obs_err, 1);
    chk("t5_access_cycles", obs_pen_run, 16);

    // reset in ACCESS: transfer lost, tie pointer back to port 0
    force_k = 99;
    new_cmd(0, 1, 32'h30, 32'h1234_5678);
    c0 = obs_rsp_cnt;
    for (int i = 0; i < 20 && !(m_busy && (cyc - m_t0) == 5); i++) step();
    chk("t6_in_access", bus.penable, 1);
    rst_drv = 1;
    step();
    rst_drv = 0;
    for (int i = 0; i < 25; i++) step();
    chk("t6_no_rsp", obs_rsp_cnt, c0);
    force_k = 0;
    grant_log.delete();
    new_cmd(0, 0, 32'h30, '0);
    new_cmd(1, 0, 32'h34, '0);
    step();
    chk("t6_tie_grant", grant_log.size() > 0 ? grant_log[0] : 9, 0);
    p_valid[1] = 0;
    drain();
    chk("t6_lost_write", obs_rdata, 0);

    // randomized soak
    force_k = -1;
    rand_mode = 1;
    for (int i = 0; i < 4000; i++) step();
    rand_mode = 0;
    rst_drv = 0;
    p_valid[0] = 0;
    p_valid[1] = 0;
    drain();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end
endmodule
